id_scoreboard: RTL and testbench

- Register-file hazard scoreboard sitting between decode and the register file read ports.
- Holds one pending-write bit per architectural register (x1..x31).
- Stalls issue of an R-type/ALU instruction whose rs1/rs2 (RAW) or rd (WAW) has a write still in flight; clears bits on writeback.
- Also counts in-flight writes and stall cycles, and supports a pipeline flush.

---
 rtl/id_scoreboard.sv | 144 ++++++++++++++
 tb/tb_id_scoreboard.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : id_scoreboard
// Purpose  : Register hazard scoreboard between decode and register read.
//            It tracks one pending-write bit per register and reports RAW/WAW
//            stalls. It also counts in-flight writes and stall cycles.
//            Optional sticky protocol-error flag under SCOREBOARD_ERR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module id_scoreboard #(
    parameter int RADDR_W      = 5,
    parameter int MAX_INFLIGHT = 4,
    parameter int CNT_W        = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               issue_valid_i,
    output logic               issue_ready_o,
    input  logic [RADDR_W-1:0] rs1_i,
    input  logic               rs1_re_i,
    input  logic [RADDR_W-1:0] rs2_i,
    input  logic               rs2_re_i,
    input  logic [RADDR_W-1:0] rd_i,
    input  logic               rd_we_i,
    input  logic               wb_valid_i,
    input  logic [RADDR_W-1:0] wb_addr_i,
    input  logic               flush_i,
    output logic               stall_o,
    output logic [31:0]        pending_o,
    output logic [2:0]         inflight_o,
    output logic [CNT_W-1:0]   stall_cnt_o,
    output logic               err_o
);

    localparam logic [2:0] c_MAX_INFLIGHT = 3'(MAX_INFLIGHT);

    logic [31:0]      r_pending;
    logic [2:0]       r_inflight;
    logic [CNT_W-1:0] r_stall_cnt;

    logic [31:0] w_clr;
    logic [31:0] w_set;
    logic [31:0] w_pending_nxt;
    logic [2:0]  w_inflight_eff;
    logic [2:0]  w_inflight_nxt;
    logic        w_clr_any;
    logic        w_raw1;
    logic        w_raw2;
    logic        w_waw;
    logic        w_full;
    logic        w_rd_live;
    logic        w_ready;
    logic        w_stall;
    logic        w_accept;

    // A writeback only clears a bit that is actually pending; x0 never is.
    always_comb begin
        w_clr = '0;
        if (wb_valid_i) begin
            w_clr[wb_addr_i] = r_pending[wb_addr_i];
        end
    end

    assign w_clr_any = |w_clr;

    // Hazards see the same-cycle writeback as already retired (bypass).
    assign w_raw1 = rs1_re_i & (rs1_i != '0) & r_pending[rs1_i] & ~w_clr[rs1_i];
    assign w_raw2 = rs2_re_i & (rs2_i != '0) & r_pending[rs2_i] & ~w_clr[rs2_i];
    assign w_waw  = rd_we_i  & (rd_i  != '0) & r_pending[rd_i]  & ~w_clr[rd_i];

    assign w_rd_live      = rd_we_i & (rd_i != '0);
    assign w_inflight_eff = r_inflight - {2'b00, w_clr_any};
    assign w_full         = (w_inflight_eff == c_MAX_INFLIGHT);

    assign w_ready  = ~rst & ~flush_i & ~w_raw1 & ~w_raw2 & ~w_waw
                    & ~(w_full & w_rd_live);
    assign w_stall  = ~rst & issue_valid_i & ~w_ready;
    assign w_accept = issue_valid_i & w_ready & w_rd_live;

    always_comb begin
        w_set = '0;
        if (w_accept) begin
            w_set[rd_i] = 1'b1;
        end
    end

    // Set is OR'ed after the clear so a same-register set/clear keeps the bit.
    assign w_pending_nxt  = ((r_pending & ~w_clr) | w_set) & 32'hFFFF_FFFE;
    assign w_inflight_nxt = r_inflight + {2'b00, w_accept} - {2'b00, w_clr_any};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending  <= '0;
            r_inflight <= '0;
        end else if (flush_i) begin
            r_pending  <= '0;
            r_inflight <= '0;
        end else begin
            r_pending  <= w_pending_nxt;
            r_inflight <= w_inflight_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !(&r_stall_cnt)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
        end
    end

`ifdef SCOREBOARD_ERR_EN
    logic r_err;
    logic r_prev_stall;
    logic w_err_evt;

    // A stall that coincides with a flush does not oblige decode to hold valid.
    assign w_err_evt = (wb_valid_i & (wb_addr_i != '0) & ~r_pending[wb_addr_i])
                     | (w_clr_any & (r_inflight == '0))
                     | (r_prev_stall & ~issue_valid_i & ~flush_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err        <= 1'b0;
            r_prev_stall <= 1'b0;
        end else begin
            r_err        <= r_err | w_err_evt;
            r_prev_stall <= w_stall & ~flush_i;
        end
    end

    assign err_o = r_err;
`else
    assign err_o = 1'b0;
`endif

    assign issue_ready_o = w_ready;
    assign stall_o       = w_stall;
    assign pending_o     = r_pending;
    assign inflight_o    = r_inflight;
    assign stall_cnt_o   = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_id_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_scoreboard
// Purpose  : Self-checking bench for id_scoreboard: directed scenarios plus
//            randomized traffic against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_id_scoreboard;

    localparam int MAX_INFLIGHT = 4;
`ifdef SCOREBOARD_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid_i;
    logic        issue_ready_o;
    logic [4:0]  rs1_i;
    logic        rs1_re_i;
    logic [4:0]  rs2_i;
    logic        rs2_re_i;
    logic [4:0]  rd_i;
    logic        rd_we_i;
    logic        wb_valid_i;
    logic [4:0]  wb_addr_i;
    logic        flush_i;
    logic        stall_o;
    logic [31:0] pending_o;
    logic [2:0]  inflight_o;
    logic [15:0] stall_cnt_o;
    logic        err_o;

    int vectors     = 0;
    int miscompares = 0;

    id_scoreboard #(.RADDR_W(5), .MAX_INFLIGHT(MAX_INFLIGHT), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .rs1_i(rs1_i), .rs1_re_i(rs1_re_i), .rs2_i(rs2_i), .rs2_re_i(rs2_re_i),
        .rd_i(rd_i), .rd_we_i(rd_we_i),
        .wb_valid_i(wb_valid_i), .wb_addr_i(wb_addr_i), .flush_i(flush_i),
        .stall_o(stall_o), .pending_o(pending_o), .inflight_o(inflight_o),
        .stall_cnt_o(stall_cnt_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    // Reference model: the set of registers with a write in flight.
    int q[$];
    int m_cnt;
    bit m_err;
    bit m_prev;

    function automatic bit in_q(int r);
        foreach (q[i]) if (q[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit wb_hits();
        return wb_valid_i && wb_addr_i != 0 && in_q(int'(wb_addr_i));
    endfunction

    function automatic bit blocked(int r, bit en);
        return en && r != 0 && in_q(r) && !(wb_hits() && int'(wb_addr_i) == r);
    endfunction

    function automatic bit m_ready();
        int eff;
        eff = q.size() - (wb_hits() ? 1 : 0);
        if (rst || flush_i) return 1'b0;
        if (blocked(int'(rs1_i), rs1_re_i) || blocked(int'(rs2_i), rs2_re_i)
            || blocked(int'(rd_i), rd_we_i)) return 1'b0;
        if (rd_we_i && rd_i != 0 && eff == MAX_INFLIGHT) return 1'b0;
        return 1'b1;
    endfunction

    function automatic bit m_stall();
        return !rst && issue_valid_i && !m_ready();
    endfunction

    function automatic logic [31:0] m_pvec();
        logic [31:0] v;
        v = '0;
        foreach (q[i]) v[q[i]] = 1'b1;
        return v;
    endfunction

    task automatic m_edge();
        bit rdy, st, acc, hit;
        rdy = m_ready();
        st  = m_stall();
        acc = issue_valid_i && rdy && rd_we_i && rd_i != 0;
        hit = wb_hits();
        if (rst) begin
            q.delete(); m_cnt = 0; m_err = 0; m_prev = 0;
            return;
        end
        if (ERR_EN) begin
            if (wb_valid_i && wb_addr_i != 0 && !in_q(int'(wb_addr_i))) m_err = 1;
            if (m_prev && !issue_valid_i && !flush_i) m_err = 1;
        end
        m_prev = st && !flush_i;
        if (st && m_cnt < 65535) m_cnt++;
        if (flush_i) begin
            q.delete();
        end else begin
            if (hit) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i] == int'(wb_addr_i)) begin q.delete(i); break; end
                end
            end
            if (acc) q.push_back(int'(rd_i));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        issue_valid_i = 0; rs1_i = 0; rs1_re_i = 0; rs2_i = 0; rs2_re_i = 0;
        rd_i = 0; rd_we_i = 0; wb_valid_i = 0; wb_addr_i = 0; flush_i = 0;
    endtask

    task automatic drive(int rd, bit we, int s1, bit e1, int s2, bit e2);
        issue_valid_i = 1; rd_i = 5'(rd); rd_we_i = we;
        rs1_i = 5'(s1); rs1_re_i = e1; rs2_i = 5'(s2); rs2_re_i = e2;
    endtask

    task automatic do_reset();
        idle(); rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic test_reset();
        idle(); rst = 1; issue_valid_i = 1; rd_we_i = 1; rd_i = 3;
        #1;
        vectors++; if (issue_ready_o !== 1'b0) begin miscompares++; $display("FAIL rst_ready got=%b want=0", issue_ready_o); end
        vectors++; if (stall_o !== 1'b0) begin miscompares++; $display("FAIL rst_stall got=%b want=0", stall_o); end
        tick(); tick(); idle(); rst = 0;
        vectors++; if (pending_o !== 32'h0) begin miscompares++; $display("FAIL rst_pending got=%h want=0", pending_o); end
        vectors++; if (inflight_o !== 3'd0) begin miscompares++; $display("FAIL rst_inflight got=%0d want=0", inflight_o); end
        vectors++; if (stall_cnt_o !== 16'd0) begin miscompares++; $display("FAIL rst_cnt got=%0d want=0", stall_cnt_o); end
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL rst_err got=%b want=0", err_o); end
    endtask

    task automatic test_raw_bypass();
        do_reset();
        drive(5, 1, 1, 1, 2, 1); #1;
        vectors++; if (issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL raw_first_ready got=%b want=1", issue_ready_o); end
        tick();
        vectors++; if (pending_o !== 32'h20) begin miscompares++; $display("FAIL raw_pending got=%h want=20", pending_o); end
        vectors++; if (inflight_o !== 3'd1) begin miscompares++; $display("FAIL raw_inflight got=%0d want=1", inflight_o); end
        drive(0, 0, 5, 1, 0, 0); #1;
        vectors++; if (stall_o !== 1'b1) begin miscompares++; $display("FAIL raw_stall got=%b want=1", stall_o); end
        tick(); tick();
        wb_valid_i = 1; wb_addr_i = 5; #1;
        vectors++; if (issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL raw_bypass_ready got=%b want=1", issue_ready_o); end
        tick(); idle();
        vectors++; if (pending_o !== 32'h0) begin miscompares++; $display("FAIL raw_after_pending got=%h want=0", pending_o); end
        vectors++; if (stall_cnt_o !== 16'd2) begin miscompares++; $display("FAIL raw_cnt got=%0d want=2", stall_cnt_o); end
    endtask

    task automatic test_full();
        do_reset();
        for (int r = 1; r <= 4; r++) begin drive(r, 1, 0, 0, 0, 0); tick(); end
        vectors++; if (inflight_o !== 3'd4) begin miscompares++; $display("FAIL full_inflight got=%0d want=4", inflight_o); end
        drive(6, 1, 0, 0, 0, 0); #1;
        vectors++; if (stall_o !== 1'b1) begin miscompares++; $display("FAIL full_stall got=%b want=1", stall_o); end
        tick();
        drive(6, 0, 0, 0, 0, 0); #1;
        vectors++; if (issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL full_nowrite_ready got=%b want=1", issue_ready_o); end
        tick();
        drive(6, 1, 0, 0, 0, 0); wb_valid_i = 1; wb_addr_i = 1; #1;
        vectors++; if (issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL full_wb_ready got=%b want=1", issue_ready_o); end
        tick(); idle();
        vectors++; if (inflight_o !== 3'd4) begin miscompares++; $display("FAIL full_wb_inflight got=%0d want=4", inflight_o); end
        vectors++; if (pending_o !== 32'h5C) begin miscompares++; $display("FAIL full_wb_pending got=%h want=5c", pending_o); end
    endtask

    task automatic test_x0();
        do_reset();
        drive(0, 1, 0, 1, 0, 1); #1;
        vectors++; if (issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL x0_ready got=%b want=1", issue_ready_o); end
        tick(); idle();
        vectors++; if (pending_o !== 32'h0) begin miscompares++; $display("FAIL x0_pending got=%h want=0", pending_o); end
        vectors++; if (inflight_o !== 3'd0) begin miscompares++; $display("FAIL x0_inflight got=%0d want=0", inflight_o); end
    endtask

    task automatic test_set_clear_same();
        do_reset();
        drive(7, 1, 0, 0, 0, 0); tick();
        drive(7, 1, 0, 0, 0, 0); wb_valid_i = 1; wb_addr_i = 7; #1;
        vectors++; if (issue_ready_o !== 1'b1) begin miscompares++; $display("FAIL same_ready got=%b want=1", issue_ready_o); end
        tick(); idle();
        vectors++; if (pending_o !== 32'h80) begin miscompares++; $display("FAIL same_pending got=%h want=80", pending_o); end
        vectors++; if (inflight_o !== 3'd1) begin miscompares++; $display("FAIL same_inflight got=%0d want=1", inflight_o); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int r = 1; r <= 3; r++) begin drive(r, 1, 0, 0, 0, 0); tick(); end
        drive(4, 1, 0, 0, 0, 0); flush_i = 1; wb_valid_i = 1; wb_addr_i = 1; #1;
        vectors++; if (issue_ready_o !== 1'b0) begin miscompares++; $display("FAIL flush_ready got=%b want=0", issue_ready_o); end
        tick(); idle();
        vectors++; if (pending_o !== 32'h0) begin miscompares++; $display("FAIL flush_pending got=%h want=0", pending_o); end
        vectors++; if (inflight_o !== 3'd0) begin miscompares++; $display("FAIL flush_inflight got=%0d want=0", inflight_o); end
        vectors++; if (stall_cnt_o !== 16'd1) begin miscompares++; $display("FAIL flush_cnt got=%0d want=1", stall_cnt_o); end
    endtask

    task automatic test_saturate();
        do_reset();
        drive(10, 1, 0, 0, 0, 0); tick();
        drive(0, 0, 10, 1, 0, 0);
        for (int i = 0; i < 65534; i++) tick();
        vectors++; if (stall_cnt_o !== 16'hFFFE) begin miscompares++; $display("FAIL sat_pre got=%h want=fffe", stall_cnt_o); end
        tick();
        vectors++; if (stall_cnt_o !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hit got=%h want=ffff", stall_cnt_o); end
        for (int i = 0; i < 5; i++) tick();
        vectors++; if (stall_cnt_o !== 16'hFFFF) begin miscompares++; $display("FAIL sat_hold got=%h want=ffff", stall_cnt_o); end
    endtask

    task automatic test_err();
        do_reset();
        wb_valid_i = 1; wb_addr_i = 9; tick(); idle();
        vectors++; if (err_o !== ERR_EN) begin miscompares++; $display("FAIL err_set got=%b want=%b", err_o, ERR_EN); end
        tick(); tick(); tick();
        vectors++; if (err_o !== ERR_EN) begin miscompares++; $display("FAIL err_hold got=%b want=%b", err_o, ERR_EN); end
        rst = 1; tick(); rst = 0;
        vectors++; if (err_o !== 1'b0) begin miscompares++; $display("FAIL err_clear got=%b want=0", err_o); end
    endtask

    task automatic test_random();
        bit er, es;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            issue_valid_i = ($urandom_range(0, 3) != 0);
            rs1_i = 5'($urandom_range(0, 7)); rs1_re_i = 1'($urandom_range(0, 1));
            rs2_i = 5'($urandom_range(0, 7)); rs2_re_i = 1'($urandom_range(0, 1));
            rd_i  = 5'($urandom_range(0, 7)); rd_we_i  = ($urandom_range(0, 3) != 0);
            wb_valid_i = ($urandom_range(0, 2) == 0);
            if (q.size() > 0 && $urandom_range(0, 3) != 0)
                wb_addr_i = 5'(q[$urandom_range(0, q.size() - 1)]);
            else
                wb_addr_i = 5'($urandom_range(0, 7));
            flush_i = ($urandom_range(0, 39) == 0);
            rst     = ($urandom_range(0, 99) == 0);
            #1;
            er = m_ready(); es = m_stall();
            vectors++; if (issue_ready_o !== er) begin miscompares++; $display("FAIL rnd_ready n=%0d got=%b want=%b", n, issue_ready_o, er); end
            vectors++; if (stall_o !== es) begin miscompares++; $display("FAIL rnd_stall n=%0d got=%b want=%b", n, stall_o, es); end
            tick();
            vectors++; if (pending_o !== m_pvec()) begin miscompares++; $display("FAIL rnd_pending n=%0d got=%h want=%h", n, pending_o, m_pvec()); end
            vectors++; if (int'(inflight_o) != q.size()) begin miscompares++; $display("FAIL rnd_inflight n=%0d got=%0d want=%0d", n, inflight_o, q.size()); end
            vectors++; if (int'(stall_cnt_o) != m_cnt) begin miscompares++; $display("FAIL rnd_cnt n=%0d got=%0d want=%0d", n, stall_cnt_o, m_cnt); end
            vectors++; if (err_o !== m_err) begin miscompares++; $display("FAIL rnd_err n=%0d got=%b want=%b", n, err_o, m_err); end
        end
        rst = 0; idle();
    endtask

    initial begin
        idle();
        rst = 1;
        @(negedge clk);
        test_reset();
        test_raw_bypass();
        test_full();
        test_x0();
        test_set_clear_same();
        test_flush();
        test_random();
        test_saturate();
        test_err();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
